// File: rtl/inst_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register read.
// The slave modport is the decode stage's view; master is the environment around it.
interface inst_decode_stage_if #(
  parameter int XLEN = 32
);
  // Upstream side: one instruction word plus its PC+4.
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc4;
  logic            in_ext_sel;

  // Downstream side: the head entry of the output queue.
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      op;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      sa;
  logic [5:0]      funct;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] out_pc4;
  logic [15:0]     inst_count;

  modport slave (
    input  in_valid, in_inst, in_pc4, in_ext_sel, out_ready,
    output in_ready, out_valid, op, rs, rt, rd, sa, funct,
           imm_ext, jump_target, branch_target, out_pc4, inst_count
  );

  modport master (
    output in_valid, in_inst, in_pc4, in_ext_sel, out_ready,
    input  in_ready, out_valid, op, rs, rt, rd, sa, funct,
           imm_ext, jump_target, branch_target, out_pc4, inst_count
  );
endinterface

// File: rtl/inst_decode_stage.sv
// Instruction-decode stage: splits MIPS fields, extends the immediate and
// precomputes jump/branch targets at capture, then buffers the decoded entry
// in a 1- or 2-deep FIFO with valid/ready flow control and a synchronous flush.
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 flush,
  inst_decode_stage_if.slave   bus
);

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sa;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc4;
  } entry_t;

  // Two slots are always declared; with DEPTH=1 both pointers stay at slot 0.
  entry_t      mem [2];
  entry_t      new_entry;
  entry_t      head;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [15:0] inst_count;
  logic        push;
  logic        pop;

  // With one slot the pointer never moves; with two it toggles.
  function automatic logic advance(input logic ptr);
    return (DEPTH == 2) ? ~ptr : 1'b0;
  endfunction

  // in_ready looks only at the registered occupancy, never at out_ready.
  assign bus.in_ready  = (count != 2'(DEPTH));
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready;

  // Decode the incoming word so the stored entry already carries every result.
  always_comb begin
    // NOTE: every field gets a default first so no path through this block can infer a latch.
    new_entry               = '0;
    new_entry.op            = bus.in_inst[31:26];
    new_entry.rs            = bus.in_inst[25:21];
    new_entry.rt            = bus.in_inst[20:16];
    new_entry.rd            = bus.in_inst[15:11];
    new_entry.sa            = bus.in_inst[10:6];
    new_entry.funct         = bus.in_inst[5:0];
    new_entry.imm_ext       = bus.in_ext_sel
                              ? {{(XLEN-16){bus.in_inst[15]}}, bus.in_inst[15:0]}
                              : {{(XLEN-16){1'b0}}, bus.in_inst[15:0]};
    new_entry.jump_target   = {bus.in_pc4[XLEN-1:28], bus.in_inst[25:0], 2'b00};
    // The branch offset is always sign-extended, whatever in_ext_sel says.
    new_entry.branch_target = bus.in_pc4
                              + {{(XLEN-18){bus.in_inst[15]}}, bus.in_inst[15:0], 2'b00};
    new_entry.pc4           = bus.in_pc4;
  end

  // FIFO storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      // NOTE: the storage is reset because the outputs must read zero out of reset;
      // that is affordable here only because the queue is at most two entries.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments, so every update here sees pre-edge values.
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= advance(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= advance(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output-transfer counter; a transfer in a flush cycle still counts, and it wraps.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      inst_count <= 16'd0;
    end else if (pop) begin
      inst_count <= inst_count + 16'd1;
    end
  end

  assign head              = mem[rd_ptr];
  assign bus.op            = head.op;
  assign bus.rs            = head.rs;
  assign bus.rt            = head.rt;
  assign bus.rd            = head.rd;
  assign bus.sa            = head.sa;
  assign bus.funct         = head.funct;
  assign bus.imm_ext       = head.imm_ext;
  assign bus.jump_target   = head.jump_target;
  assign bus.branch_target = head.branch_target;
  assign bus.out_pc4       = head.pc4;
  assign bus.inst_count    = inst_count;

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered, handshaked instruction-decode stage for the multi-cycle CPU. It sits between instruction fetch and register read. It accepts a 32-bit instruction word plus its PC+4, splits out the MIPS fields, extends the immediate, and precomputes the jump and branch targets. Results are buffered in a 1- or 2-entry output queue under valid/ready flow control, with a synchronous flush for control-flow redirects.

## Interface
Parameters:
- XLEN, 32: width of PC, extended immediate and target outputs; legal values ≥ 32.
- DEPTH, 2: output buffer entries; legal values 1 or 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_inst  in  32  instruction word.
- in_pc4  in  XLEN  PC+4 of the instruction.
- in_ext_sel  in  1  1 = sign-extend immediate; 0 = zero-extend.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head entry.
- op  out  6  inst[31:26].
- rs  out  5  inst[25:21].
- rt  out  5  inst[20:16].
- rd  out  5  inst[15:11].
- sa  out  5  inst[10:6].
- funct  out  6  inst[5:0].
- imm_ext  out  XLEN  inst[15:0], extended per in_ext_sel.
- jump_target  out  XLEN  {in_pc4[XLEN-1:28], inst[25:0], 2'b00}.
- branch_target  out  XLEN  in_pc4 + (signext(inst[15:0]) << 2), modulo 2^XLEN.
- out_pc4  out  XLEN  buffered in_pc4.
- inst_count  out  16  number of output transfers; wraps.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Decode happens at capture. All field, extension and target values are computed from in_* and stored in the entry. The outputs always show the head entry's stored values.
- branch_target always uses sign extension, regardless of in_ext_sel. imm_ext honours in_ext_sel.
- The buffer is a FIFO of DEPTH entries with occupancy count 0..DEPTH. out_valid = (count != 0).
- DEPTH=2:
  - in_ready = (count != 2).
  - Push and pop in the same cycle leave count unchanged, and the new entry queues behind the head.
  - Sustains one instruction per cycle.
- DEPTH=1:
  - in_ready = (count == 0).
  - Maximum throughput is one instruction per two cycles.
- in_ready depends only on registered state. There is no combinational path from out_ready.
- Flush:
  - Sets count to 0 at the next edge.
  - Any input transfer in the same cycle is discarded.
  - An output transfer in the flush cycle is still counted in inst_count.
  - Flush has priority over push and pop.
- When the buffer is empty, data outputs hold their last values. They are don't-care while out_valid=0.
- inst_count increments by 1 on every output transfer and wraps from 0xFFFF to 0x0000. Flush does not clear it.

## Timing
- Reset (asynchronous assert, released synchronously by the environment): count=0, out_valid=0, in_ready=1, inst_count=0, all data outputs 0.
- Reset asserted mid-operation clears all state immediately, with no clock required.
- Latency: an entry accepted at edge N is presented with out_valid=1 after edge N.
- While out_valid=1 && out_ready=0, all outputs stay stable until the transfer completes or flush is asserted.

## Test plan
- Reset, then push in_inst=0x00851020, in_pc4=0x00400004 → next cycle out_valid=1, op=0, rs=4, rt=5, rd=2, sa=0, funct=0x20, inst_count=0; pop → inst_count=1.
- Push 0x8C22FFFC, pc4=0x00400004, ext_sel=1 → op=0x23, rs=1, rt=2, imm_ext=0xFFFFFFFC, branch_target=0x003FFFF4; repeat with ext_sel=0 → imm_ext=0x0000FFFC, branch_target unchanged.
- Push 0x08100003, pc4=0x00400004 → op=2, jump_target=0x0040000C; with pc4=0xF0000000 → jump_target=0xF040000C.
- DEPTH=2, out_ready=0, push 3 back-to-back → in_ready drops after 2 pushes and the third is held upstream. Then out_ready=1 with continuous in_valid → one output per cycle, entries in order, no loss or duplication.
- Full buffer, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed-cycle input is absent, inst_count unchanged. Reset asserted mid-stream → outputs zero immediately without a clock edge.
- DEPTH=1, continuous in_valid and out_ready=1 → accepts every other cycle; 10 instructions complete in 20 cycles.
